mix_store_ctrl: RTL

- Sequences MIX store instructions (STA/STX/STJ/STZ/STi) against main memory.
- Accepts a store command from the instruction sequencer: register word, field spec F=8L+R and address.
- Performs read-modify-write with the field merge done internally. Full-word stores skip the read.
- Sits between the instruction sequencer and the memory port, using the codebase start/stop handshake.

---
 rtl/mix_store_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mix_store_ctrl.sv
// MIX store sequencer: latches a store command, reads the target word when a partial field is
// stored, merges the register bytes in, and writes the result back through the memory port.
module mix_store_ctrl #(
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [5:0]    field,
  input  logic [AW-1:0] addr,
  input  logic [30:0]   reg_in,
  output logic          stop,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [30:0]   mem_rdata,
  output logic          mem_wr,
  output logic [30:0]   mem_wdata,
  input  logic          mem_ack
);

  localparam int unsigned CntBits = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CntBits-1:0] CntLast = CntBits'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StMerge,
    StWrite,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [5:0]           field_q, field_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [30:0]          reg_q, reg_d;
  logic [30:0]          rdata_q, rdata_d;
  logic [30:0]          wdata_q, wdata_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic                 err_q, err_d;

  function automatic logic field_ok(logic [5:0] f);
    return (f[5:3] <= 3'd5) && (f[2:0] <= 3'd5) && (f[5:3] <= f[2:0]);
  endfunction

  // Byte b of the result takes register byte b+(5-R): shift the register bytes left by 5-R
  // byte positions, then select bytes L'..R with a mask. Only called with a valid field.
  function automatic logic [30:0] merge_word(logic [30:0] m, logic [30:0] r, logic [2:0] l,
                                             logic [2:0] rr);
    logic [30:0] res;
    logic [29:0] aligned;
    logic [29:0] mask;
    logic [2:0]  lp;
    int unsigned sh;
    res     = m;
    mask    = '0;
    lp      = (l == 3'd0) ? 3'd1 : l;
    sh      = 6 * (5 - int'(rr));
    aligned = r[29:0] << sh;
    if (l == 3'd0) res[30] = r[30];
    for (int b = 1; b <= 5; b++) begin
      if (b >= int'(lp) && b <= int'(rr)) mask[35-6*b -: 6] = 6'h3f;
    end
    res[29:0] = (m[29:0] & ~mask) | (aligned & mask);
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          field_d = field;
          addr_d  = addr;
          reg_d   = reg_in;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!field_ok(field)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (field == 6'd5) begin
            wdata_d = reg_in;
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end

      StRead: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = StMerge;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StMerge: begin
        wdata_d = merge_word(rdata_q, reg_q, field_q[5:3], field_q[2:0]);
        cnt_d   = '0;
        state_d = StWrite;
      end

      StWrite: begin
        // An ack in the limit cycle takes priority over the abort.
        if (mem_ack) begin
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      field_q <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stop      = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign mem_rd    = (state_q == StRead);
  assign mem_wr    = (state_q == StWrite);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule
